fetch_pc_redirect: RTL and testbench

//  Next-PC generator and branch-resolution tracker for the IF stage. Drives pc_cur_if to the

---
 rtl/fetch_pc_redirect.sv | 121 ++++++++++++
 tb/tb_fetch_pc_redirect.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_redirect
// Brief    : IF-stage next-PC generator. Carries each fetched PC's prediction
//            through IF->ID->EX and redirects fetch when EX disagrees with it.
// Revision : 1.0
// ============================================================================
module fetch_pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_predict,
    input  logic [31:0]      branch_addr,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic [31:0]      pc_cur_if,
    output logic [31:0]      pc_cur_ex,
    output logic             update_en,
    output logic             branch_outcome,
    output logic             predict_outcome,
    output logic [31:0]      update_addr,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [31:0]      pc_if_q,    pc_if_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_pc_q,    id_pc_d;
    logic             id_pred_q,  id_pred_d;
    logic [31:0]      id_ptgt_q,  id_ptgt_d;
    logic             ex_valid_q, ex_valid_d;
    logic [31:0]      ex_pc_q,    ex_pc_d;
    logic             ex_pred_q,  ex_pred_d;
    logic [31:0]      ex_ptgt_q,  ex_ptgt_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             w_resolve;
    logic             w_mispredict;
    logic [31:0]      w_correct_pc;

    // Gating with rst keeps every predictor-facing output quiet while reset is held.
    assign w_resolve    = ex_valid_q & ex_is_branch & ~rst;
    assign w_mispredict = w_resolve &
                          ((ex_taken != ex_pred_q) | (ex_taken & (ex_target != ex_ptgt_q)));
    assign w_correct_pc = ex_taken ? ex_target : (ex_pc_q + 32'd4);

    assign pc_cur_if       = pc_if_q;
    assign pc_cur_ex       = ex_pc_q;
    assign update_en       = w_resolve;
    assign branch_outcome  = w_resolve & ex_taken;
    assign predict_outcome = w_resolve & ~w_mispredict;
    assign update_addr     = w_resolve ? ex_target : 32'd0;
    assign flush           = w_mispredict;
    assign mispredict_cnt  = cnt_q;

    always_comb begin
        pc_if_d    = pc_if_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pred_d  = id_pred_q;
        id_ptgt_d  = id_ptgt_q;
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_pred_d  = ex_pred_q;
        ex_ptgt_d  = ex_ptgt_q;
        cnt_d      = cnt_q;

        if (w_mispredict) begin
            pc_if_d    = w_correct_pc;
            id_valid_d = 1'b0;
            ex_valid_d = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (stall) begin
            ex_valid_d = 1'b0;
        end else begin
            pc_if_d    = branch_predict ? branch_addr : (pc_if_q + 32'd4);
            id_valid_d = 1'b1;
            id_pc_d    = pc_if_q;
            id_pred_d  = branch_predict;
            id_ptgt_d  = branch_addr;
            ex_valid_d = id_valid_q;
            ex_pc_d    = id_pc_q;
            ex_pred_d  = id_pred_q;
            ex_ptgt_d  = id_ptgt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_if_q    <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_pred_q  <= 1'b0;
            id_ptgt_q  <= 32'd0;
            ex_valid_q <= 1'b0;
            ex_pc_q    <= 32'd0;
            ex_pred_q  <= 1'b0;
            ex_ptgt_q  <= 32'd0;
            cnt_q      <= '0;
        end else begin
            pc_if_q    <= pc_if_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pred_q  <= id_pred_d;
            id_ptgt_q  <= id_ptgt_d;
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_pred_q  <= ex_pred_d;
            ex_ptgt_q  <= ex_ptgt_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_redirect
// Brief    : Directed and random stimulus for fetch_pc_redirect, checked
//            against an in-bench model of the fetch/resolve pipeline.
// Revision : 1.0
// ============================================================================
module tb_fetch_pc_redirect;

    logic        clk = 1'b0;
    logic        rst, stall, branch_predict, ex_is_branch, ex_taken;
    logic [31:0] branch_addr, ex_target;

    logic [31:0] pc_cur_if, pc_cur_ex, update_addr;
    logic        update_en, branch_outcome, predict_outcome, flush;
    logic [15:0] mispredict_cnt;

    logic [31:0] pc2_if, pc2_ex, upd2_addr;
    logic        upd2_en, bo2, po2, fl2;
    logic [1:0]  cnt2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: expected fetch PC plus the in-flight instruction records
    typedef struct { bit v; logic [31:0] pc; bit pred; logic [31:0] ptgt; } rec_t;
    logic [31:0] m_pc;
    rec_t        m_id, m_ex;
    int          m_cnt;

    always #5 clk = ~clk;

    fetch_pc_redirect dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_predict(branch_predict), .branch_addr(branch_addr),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .pc_cur_if(pc_cur_if), .pc_cur_ex(pc_cur_ex), .update_en(update_en),
        .branch_outcome(branch_outcome), .predict_outcome(predict_outcome),
        .update_addr(update_addr), .flush(flush), .mispredict_cnt(mispredict_cnt)
    );

    fetch_pc_redirect #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_predict(branch_predict), .branch_addr(branch_addr),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .pc_cur_if(pc2_if), .pc_cur_ex(pc2_ex), .update_en(upd2_en),
        .branch_outcome(bo2), .predict_outcome(po2),
        .update_addr(upd2_addr), .flush(fl2), .mispredict_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input int w);
        int mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    function automatic bit m_resolve();
        return !rst && m_ex.v && ex_is_branch;
    endfunction

    function automatic bit m_misp();
        return m_resolve() && ((ex_taken != m_ex.pred) ||
                               (ex_taken && (ex_target != m_ex.ptgt)));
    endfunction

    task automatic check_model();
        if (chk_en) begin
            chk("pc_if",   pc_cur_if, m_pc);
            chk("pc_ex",   pc_cur_ex, m_ex.pc);
            chk("upd_en",  {31'd0, update_en}, {31'd0, m_resolve()});
            chk("flush",   {31'd0, flush}, {31'd0, m_misp()});
            chk("cnt16",   {16'd0, mispredict_cnt}, sat(m_cnt, 16));
            chk("cnt2",    {30'd0, cnt2}, sat(m_cnt, 2));
            if (m_resolve()) begin
                chk("pred_ok", {31'd0, predict_outcome}, {31'd0, !m_misp()});
                chk("outcome", {31'd0, branch_outcome}, {31'd0, ex_taken});
                chk("upd_addr", update_addr, ex_target);
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] a,
                         input logic ib, input logic t, input logic [31:0] g);
        rst = r; stall = s; branch_predict = b; branch_addr = a;
        ex_is_branch = ib; ex_taken = t; ex_target = g;
    endtask

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] a,
                       input logic ib, input logic t, input logic [31:0] g);
        drive(r, s, b, a, ib, t, g);
        #1;
        check_model();
    endtask

    // Advance the model with the inputs presented this cycle, then cross the edge.
    task automatic tick();
        logic [31:0] n_pc;
        rec_t        n_id, n_ex;
        int          n_cnt;
        n_pc = m_pc; n_id = m_id; n_ex = m_ex; n_cnt = m_cnt;
        if (rst) begin
            n_pc = 32'h0; n_cnt = 0;
            n_id = '{0, 32'h0, 0, 32'h0};
            n_ex = '{0, 32'h0, 0, 32'h0};
        end else if (m_misp()) begin
            n_pc = ex_taken ? ex_target : m_ex.pc + 32'd4;
            n_id.v = 0; n_ex.v = 0; n_cnt = m_cnt + 1;
        end else if (stall) begin
            n_ex.v = 0;
        end else begin
            n_ex = m_id;
            n_id = '{1, m_pc, branch_predict, branch_addr};
            n_pc = branch_predict ? branch_addr : m_pc + 32'd4;
        end
        @(posedge clk);
        m_pc = n_pc; m_id = n_id; m_ex = n_ex; m_cnt = n_cnt;
        @(negedge clk);
    endtask

    task automatic run(input logic r, input logic s, input logic b, input logic [31:0] a,
                       input logic ib, input logic t, input logic [31:0] g);
        cyc(r, s, b, a, ib, t, g);
        tick();
    endtask

    // Steer fetch to addr with a predicted-taken jump that EX will later ignore.
    task automatic goto(input logic [31:0] addr);
        run(0, 0, 1, addr, 0, 0, 0);
    endtask

    initial begin
        m_pc = 0; m_cnt = 0;
        m_id = '{0, 32'h0, 0, 32'h0};
        m_ex = '{0, 32'h0, 0, 32'h0};

        // Reset for two cycles; DUT state is unknown before the first edge.
        run(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0, 1, 1, 32'h55);
        chk("rst_pc", pc_cur_if, 32'h0);
        chk("rst_upd", {31'd0, update_en}, 32'd0);
        tick();

        // Sequential fetch
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("t1_pc", pc_cur_if, 32'(4 * k));
            chk("t1_upd", {31'd0, update_en}, 32'd0);
            tick();
        end

        // Correct taken prediction at 0x10
        run(0, 0, 1, 32'h40, 0, 0, 0);
        chk("t2_next", pc_cur_if, 32'h40);
        run(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h40);
        chk("t2_pcex", pc_cur_ex, 32'h10);
        chk("t2_upd", {31'd0, update_en}, 32'd1);
        chk("t2_ok", {31'd0, predict_outcome}, 32'd1);
        chk("t2_flush", {31'd0, flush}, 32'd0);
        tick();

        // Predicted not-taken at 0x20, actually taken to 0x80
        goto(32'h20);
        run(0, 0, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h80);
        chk("t3_flush", {31'd0, flush}, 32'd1);
        chk("t3_ok", {31'd0, predict_outcome}, 32'd0);
        tick();
        chk("t3_pc", pc_cur_if, 32'h80);
        chk("t3_cnt", {16'd0, mispredict_cnt}, 32'd1);

        // Predicted taken to 0x100 at 0x30: wrong direction, then wrong target
        for (int v = 0; v < 2; v++) begin
            goto(32'h30);
            run(0, 0, 1, 32'h100, 0, 0, 0);
            run(0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, v[0], 32'h104);
            chk("t4_flush", {31'd0, flush}, 32'd1);
            tick();
            chk("t4_pc", pc_cur_if, (v == 0) ? 32'h34 : 32'h104);
        end

        // Stall coinciding with a mispredict: redirect wins
        goto(32'h50);
        run(0, 0, 0, 0, 0, 0, 0);
        run(0, 0, 0, 0, 0, 0, 0);
        run(0, 1, 0, 0, 1, 1, 32'h200);
        chk("t5_pc", pc_cur_if, 32'h200);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 32'h999c, 1, 1, 32'h300);
            chk("t5_upd", {31'd0, update_en}, 32'd0);
            tick();
            chk("t5_hold", pc_cur_if, 32'h200);
        end
        run(0, 0, 0, 0, 1, 0, 0);
        run(0, 0, 0, 0, 1, 1, 32'h204);

        // Counter saturation on the narrow instance
        while (m_cnt < 5) begin
            goto(32'h60);
            run(0, 0, 0, 0, 0, 0, 0);
            run(0, 0, 0, 0, 0, 0, 0);
            run(0, 0, 0, 0, 1, 1, 32'h300);
        end
        chk("t6_sat", {30'd0, cnt2}, 32'd3);

        // Reset during an in-flight branch
        goto(32'h70);
        run(0, 0, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h500);
        chk("t6_rpc", pc_cur_if, 32'h0);
        chk("t6_rupd", {31'd0, update_en}, 32'd0);
        tick();
        cyc(0, 0, 0, 0, 1, 1, 32'h500);
        chk("t6_rupd2", {31'd0, update_en}, 32'd0);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_b, r_ib, r_t, r_s, r_r;
            logic [31:0] r_a, r_g;
            r_r  = ($urandom_range(0, 59) == 0);
            r_s  = ($urandom_range(0, 7) == 0);
            r_b  = ($urandom_range(0, 3) == 0);
            r_a  = $urandom & 32'hffff_fffc;
            r_ib = $urandom_range(0, 1);
            r_t  = ($urandom_range(0, 1) == 1) ? m_ex.pred : 1'($urandom_range(0, 1));
            r_g  = ($urandom_range(0, 2) != 0) ? m_ex.ptgt : ($urandom & 32'hffff_fffc);
            run(r_r, r_s, r_b, r_a, r_ib, r_t, r_g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
